// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load/store unit driving the data port of the byte-addressed mem.
//
// Accepts one load or store at a time, range/size checks it, and splits
// misaligned accesses into ascending byte beats. Loads collect bytes from
// mem's synchronous read port and sign/zero-extend here. mem is always read
// unsigned.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous, active-low reset
//   req_i      request strobe, sampled only in IDLE
//   we_i       0 load, 1 store
//   signed_i   load sign-extension enable
//   size_i     00 byte, 01 half, 10 word, 11 illegal
//   addr_i     byte address
//   wdata_i    store data, little-endian
//   busy_o     high whenever the FSM is not IDLE
//   done_o     one-cycle completion pulse
//   err_o      valid with done_o: range or size error, no access made
//   rdata_o    load result, held until the next load completes
//   memRW_o    to mem memRW_i (1 = write)
//   signed_o   to mem signed_i, tied 0
//   dataSec_o  to mem dataSec_i
//   dataW_o    to mem dataW_i
//   addr_o     to mem addr_i
//   data_i     from mem data_sync_o, valid one cycle after addr_o
// -----------------------------------------------------------------------------
module lsu #(
  parameter int unsigned MEM_TOP = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic        signed_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        memRW_o,
  output logic        signed_o,
  output logic [1:0]  dataSec_o,
  output logic [31:0] dataW_o,
  output logic [31:0] addr_o,
  input  logic [31:0] data_i
);

  typedef enum logic [2:0] {IDLE, ST_BEAT, LD_ISSUE, LD_CAPT, DONE} state_t;

  state_t      state_q;
  logic        signed_q, aligned_q;
  logic [1:0]  size_q, k_q, last_q;
  logic [31:0] addr_q, wdata_q, asm_q;
  logic        busy_q, done_q, err_q, memrw_q;
  logic [1:0]  sec_q;
  logic [31:0] dataw_q, addro_q, rdata_q;

  // Request decode (only meaningful in IDLE)
  logic [2:0]  nbytes_in;
  logic [32:0] end_addr;
  logic        bad_in, aligned_in;
  logic [1:0]  last_in;

  always_comb begin
    case (size_i)
      2'b00:   nbytes_in = 3'd1;
      2'b01:   nbytes_in = 3'd2;
      default: nbytes_in = 3'd4;
    endcase
    // 33-bit sum so addresses near 2^32 cannot wrap into range
    end_addr   = {1'b0, addr_i} + 33'(nbytes_in) - 33'd1;
    bad_in     = (size_i == 2'b11) || (end_addr > 33'(MEM_TOP));
    aligned_in = (size_i == 2'b00) ||
                 (size_i == 2'b01 && !addr_i[0]) ||
                 (size_i == 2'b10 && addr_i[1:0] == 2'b00);
    last_in    = aligned_in ? 2'd0 : 2'(nbytes_in - 3'd1);
  end

  // Next-beat values and load assembly
  logic [1:0]  k_nx;
  logic [31:0] addr_nx, asm_merged, raw, ext;

  always_comb begin
    k_nx    = k_q + 2'd1;
    addr_nx = addr_q + {30'd0, k_nx};
    asm_merged = asm_q;
    asm_merged[{k_q, 3'b000} +: 8] = data_i[7:0];
    if (aligned_q) begin
      case (size_q)
        2'b00:   raw = {24'd0, data_i[7:0]};
        2'b01:   raw = {16'd0, data_i[15:0]};
        default: raw = data_i;
      endcase
    end else begin
      raw = asm_merged;
    end
    // raw is already zero-filled above the access width
    ext = raw;
    if (signed_q && size_q == 2'b00) ext = {{24{raw[7]}}, raw[7:0]};
    if (signed_q && size_q == 2'b01) ext = {{16{raw[15]}}, raw[15:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      signed_q  <= 1'b0;
      aligned_q <= 1'b0;
      size_q    <= 2'd0;
      k_q       <= 2'd0;
      last_q    <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      asm_q     <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      memrw_q   <= 1'b0;
      sec_q     <= 2'd0;
      dataw_q   <= 32'd0;
      addro_q   <= 32'd0;
      rdata_q   <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            signed_q  <= signed_i;
            size_q    <= size_i;
            addr_q    <= addr_i;
            wdata_q   <= wdata_i;
            aligned_q <= aligned_in;
            last_q    <= last_in;
            k_q       <= 2'd0;
            asm_q     <= 32'd0;
            busy_q    <= 1'b1;
            if (bad_in) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              addro_q <= addr_i;
              sec_q   <= aligned_in ? size_i : 2'b00;
              if (we_i) begin
                state_q <= ST_BEAT;
                memrw_q <= 1'b1;
                dataw_q <= aligned_in ? wdata_i : {24'd0, wdata_i[7:0]};
              end else begin
                state_q <= LD_ISSUE;
              end
            end
          end
        end
        ST_BEAT: begin
          if (k_q == last_q) begin
            state_q <= DONE;
            memrw_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            k_q     <= k_nx;
            addro_q <= addr_nx;
            dataw_q <= {24'd0, wdata_q[{k_nx, 3'b000} +: 8]};
          end
        end
        LD_ISSUE: state_q <= LD_CAPT;
        LD_CAPT: begin
          asm_q <= asm_merged;
          if (aligned_q || k_q == last_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            rdata_q <= ext;
          end else begin
            state_q <= LD_ISSUE;
            k_q     <= k_nx;
            addro_q <= addr_nx;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign memRW_o   = memrw_q;
  assign signed_o  = 1'b0;
  assign dataSec_o = sec_q;
  assign dataW_o   = dataw_q;
  assign addr_o    = addro_q;

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu -- self-checking bench for lsu. A byte-array mem stands in for the
// real memory; expectations come from a transaction-level reference model
// (ref_mem) that applies each access directly by its byte semantics.
// -----------------------------------------------------------------------------
module tb_lsu;

  localparam int TOP = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i, signed_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, done_o, err_o, memRW_o, signed_o;
  logic [31:0] rdata_o, dataW_o, addr_o;
  logic [1:0]  dataSec_o;
  logic [31:0] data_sync;

  int          checks = 0;
  int          errors = 0;
  int          txn_no = 0;
  logic [31:0] exp_rdata;
  logic [7:0]  ref_mem [0:TOP];
  logic [7:0]  mem_env [0:TOP];
  logic        init_req;

  always #5 clk = ~clk;

  lsu #(.MEM_TOP(TOP)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .signed_i(signed_i),
    .size_i(size_i), .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .memRW_o(memRW_o),
    .signed_o(signed_o), .dataSec_o(dataSec_o), .dataW_o(dataW_o),
    .addr_o(addr_o), .data_i(data_sync)
  );

  function automatic int sec_bytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  // Environment memory: synchronous write, synchronous unsigned read
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i <= TOP; i++) mem_env[i] <= ref_mem[i];
    end else if (memRW_o) begin
      for (int k = 0; k < 4; k++)
        if (k < sec_bytes(dataSec_o) && ({1'b0, addr_o} + 33'(k) <= 33'(TOP)))
          mem_env[int'(addr_o) + k] <= dataW_o[8*k +: 8];
    end
    begin
      logic [31:0] v;
      v = 32'd0;
      for (int k = 0; k < 4; k++)
        if (k < sec_bytes(dataSec_o) && ({1'b0, addr_o} + 33'(k) <= 33'(TOP)))
          v[8*k +: 8] = mem_env[int'(addr_o) + k];
      data_sync <= v;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem();
    bit same;
    same = 1'b1;
    for (int i = 0; i <= TOP; i++) if (mem_env[i] !== ref_mem[i]) same = 1'b0;
    chk("mem_contents", 32'(same), 32'd1);
  endtask

  task automatic do_txn(input bit we, input bit sg, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold);
    int n, nbeats, exp_lat, c, nw;
    bit aln, bad, busy_ok, done_seen;
    n       = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    bad     = (sz == 2'b11) || (64'(a) + 64'(n) - 64'd1 > 64'(TOP));
    aln     = (sz == 2'b00) || (sz == 2'b01 && a[0] == 1'b0) || (sz == 2'b10 && a[1:0] == 2'b00);
    nbeats  = aln ? 1 : n;
    exp_lat = bad ? 1 : (we ? nbeats + 1 : 2 * nbeats + 1);
    if (!bad) begin
      if (we) begin
        for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
      end else begin
        logic [31:0] v;
        v = 32'd0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[int'(a) + k];
        if (sg && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (sg && n == 2) v = {{16{v[15]}}, v[15:0]};
        exp_rdata = v;
      end
    end

    @(negedge clk);
    req_i = 1'b1; we_i = we; signed_i = sg; size_i = sz; addr_i = a; wdata_i = wd;
    @(posedge clk);
    #1;
    if (hold) begin
      // keep req high with unrelated fields; the unit must ignore them
      we_i = ~we; signed_i = ~sg; size_i = 2'($urandom_range(0, 2));
      addr_i = 32'($urandom_range(0, TOP)); wdata_i = $urandom;
    end else begin
      req_i = 1'b0;
    end

    c = 0; nw = 0; busy_ok = 1'b1; done_seen = 1'b0;
    while (!done_seen && c < 20) begin
      @(negedge clk);
      c++;
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      if (memRW_o === 1'b1) begin
        if (nw < 4) begin
          chk("beat_addr", addr_o, aln ? a : a + 32'(nw));
          chk("beat_data", dataW_o, aln ? wd : {24'd0, wd[8*nw +: 8]});
          chk("beat_sec", 32'(dataSec_o), aln ? 32'(sz) : 32'd0);
        end
        nw++;
      end
      if (done_o === 1'b1) done_seen = 1'b1;
    end
    chk("done_seen", 32'(done_seen), 32'd1);
    chk("latency", 32'(c), 32'(exp_lat));
    chk("err", 32'(err_o), 32'(bad));
    chk("rdata", rdata_o, exp_rdata);
    chk("writes", 32'(nw), (we && !bad) ? 32'(nbeats) : 32'd0);
    chk("busy_during", 32'(busy_ok), 32'd1);
    chk("signed_o", 32'(signed_o), 32'd0);

    @(negedge clk);
    chk("done_after", 32'(done_o), 32'd0);
    chk("idle_after", 32'(busy_o), 32'd0);
    req_i = 1'b0;
    chk_mem();
    txn_no++;
    $display("txn %0d we=%0d sg=%0d sz=%0d addr=%08h wdata=%08h hold=%0d -> cycles=%0d err=%0d rdata=%08h",
             txn_no, we, sg, sz, a, wd, hold, c, err_o, rdata_o);
  endtask

  initial begin
    rst = 1'b0; req_i = 1'b0; we_i = 1'b0; signed_i = 1'b0; size_i = 2'd0;
    addr_i = 32'd0; wdata_i = 32'd0; exp_rdata = 32'd0; init_req = 1'b1;
    for (int i = 0; i <= TOP; i++) ref_mem[i] = 8'($urandom);

    // Reset values apply without any clock edge
    #2;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_memrw", 32'(memRW_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_addr", addr_o, 32'd0);
    chk("rst_sec", 32'(dataSec_o), 32'd0);
    chk("rst_dataw", dataW_o, 32'd0);
    repeat (2) @(negedge clk);
    init_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Aligned word store/load, byte and half loads
    do_txn(1, 0, 2'b10, 32'd8, 32'hDEADBEEF, 0);
    do_txn(0, 0, 2'b10, 32'd8, 32'd0, 0);
    chk("word_value", rdata_o, 32'hDEADBEEF);
    do_txn(0, 1, 2'b00, 32'd8, 32'd0, 0);
    chk("byte_signed", rdata_o, 32'hFFFFFFEF);
    do_txn(0, 0, 2'b00, 32'd8, 32'd0, 0);
    chk("byte_unsigned", rdata_o, 32'h000000EF);
    do_txn(0, 1, 2'b01, 32'd10, 32'd0, 0);
    chk("half_signed", rdata_o, 32'hFFFFDEAD);

    // Misaligned half store/load
    do_txn(1, 0, 2'b01, 32'd5, 32'h00001234, 0);
    do_txn(0, 1, 2'b01, 32'd5, 32'd0, 0);
    chk("mis_half", rdata_o, 32'h00001234);

    // Misaligned word load across two stored words
    do_txn(1, 0, 2'b10, 32'd8, 32'h11223344, 0);
    do_txn(1, 0, 2'b10, 32'd12, 32'h55667788, 0);
    do_txn(0, 0, 2'b10, 32'd9, 32'd0, 0);
    chk("mis_word", rdata_o, 32'h88112233);

    // Range and size errors, including the last in-range word
    do_txn(1, 0, 2'b10, 32'd18, 32'hCAFEF00D, 0);
    do_txn(1, 0, 2'b10, 32'hFFFFFFFF, 32'hCAFEF00D, 0);
    do_txn(0, 0, 2'b11, 32'd0, 32'd0, 0);
    do_txn(1, 0, 2'b10, 32'd17, 32'hA5A55A5A, 0);
    do_txn(0, 0, 2'b00, 32'd20, 32'd0, 0);
    do_txn(0, 0, 2'b00, 32'd21, 32'd0, 0);

    // Reset after the first beat of a misaligned half store
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; signed_i = 1'b0; size_i = 2'b01;
    addr_i = 32'd5; wdata_i = 32'h0000ABCD;
    @(posedge clk);
    #1 req_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_memrw", 32'(memRW_o), 32'd0);
    chk("midrst_rdata", rdata_o, 32'd0);
    ref_mem[5] = 8'hCD;
    exp_rdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk_mem();
    rst = 1'b1;
    $display("txn reset-abort: store half @5 cut after beat 0");
    do_txn(0, 0, 2'b01, 32'd5, 32'd0, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      bit          rwe, rsg, rhold;
      int          r;
      logic [1:0]  rsz;
      logic [31:0] ra;
      rwe   = 1'($urandom_range(0, 1));
      rsg   = 1'($urandom_range(0, 1));
      r     = $urandom_range(0, 15);
      rsz   = (r == 15) ? 2'b11 : 2'(r % 3);
      ra    = ($urandom_range(0, 9) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                          : 32'($urandom_range(0, TOP + 2));
      rhold = ($urandom_range(0, 3) == 0);
      do_txn(rwe, rsg, rsz, ra, $urandom, rhold);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
